// File: rtl/uart_line_loader.sv
// uart_line_loader: receives one framed video line over a byte-level UART
// interface and streams the payload into an external line buffer. Responses
// (ACK / status codes) go through a 2-entry queue to the byte transmitter.
module uart_line_loader #(
   parameter int unsigned LINE_BYTES     = 240,
   parameter int unsigned ROW_W          = 9,
   parameter int unsigned ADDR_W         = 8,
   parameter logic [7:0]  START_CODE     = 8'hA5,
   parameter logic [7:0]  END_CODE       = 8'hDD,
   parameter logic [7:0]  ANSWER_CODE    = 8'hAA,
   parameter logic [7:0]  SUCCESS_CODE   = 8'hFF,
   parameter logic [7:0]  NACK_CODE      = 8'h11,
   parameter logic [7:0]  TIMEOUT_CODE   = 8'h22,
   parameter int unsigned ACK_EVERY      = 1,
   parameter bit          CHECKSUM_EN    = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ROW_W-1:0]  row,
   output logic              line_done,
   output logic              line_err,
   output logic              active
);

   localparam logic [15:0] LB16     = 16'(LINE_BYTES);
   localparam bit          ACK_EN   = (ACK_EVERY != 0);
   localparam logic [15:0] ACK_LAST = (ACK_EVERY == 0) ? 16'd0 : 16'(ACK_EVERY - 1);
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ROW_HI, S_ROW_LO, S_PAYLOAD, S_CKSUM, S_ENDW
   } state_t;

   state_t            r_state, w_state_n;
   logic [7:0]        r_row_hi;
   logic [ROW_W-1:0]  r_row;
   logic [15:0]       r_count;
   logic [15:0]       r_ack_cnt;
   logic [7:0]        r_cksum;
   logic              r_ck_ok;
   logic [31:0]       r_tmo_cnt;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic              r_done, r_err;
   logic [7:0]        r_q0, r_q1;
   logic [1:0]        r_qcnt;
   logic              r_tx_start;
   logic [7:0]        r_tx_data;

   logic [15:0] w_cnt_inc;
   logic        w_ack_hit;
   logic        w_tmo;
   logic        w_pop;
   logic        w_push;
   logic [7:0]  w_push_data;
   logic        w_done, w_err;
   logic        w_start, w_hi_ld, w_row_ld, w_pay, w_ck_ld;

   assign w_cnt_inc = r_count + 16'd1;
   assign w_ack_hit = ACK_EN && (r_ack_cnt == ACK_LAST);
   // rx_valid in the expiry cycle wins, so expiry requires no byte this cycle
   assign w_tmo     = TMO_EN && (r_state != S_IDLE) && !rx_valid && (r_tmo_cnt == TMO_LAST);
   assign w_pop     = (r_qcnt != 2'd0) && !tx_busy && !r_tx_start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   // Next-state decode and response/status event generation
   always_comb begin
      w_state_n   = r_state;
      w_push      = 1'b0;
      w_push_data = '0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_start     = 1'b0;
      w_hi_ld     = 1'b0;
      w_row_ld    = 1'b0;
      w_pay       = 1'b0;
      w_ck_ld     = 1'b0;
      if (w_tmo) begin
         w_push      = 1'b1;
         w_push_data = TIMEOUT_CODE;
         w_err       = 1'b1;
         w_state_n   = S_IDLE;
      end else if (rx_valid) begin
         case (r_state)
            S_IDLE: begin
               if (rx_data == START_CODE) begin
                  w_start   = 1'b1;
                  w_state_n = S_ROW_HI;
               end
            end
            S_ROW_HI: begin
               w_hi_ld   = 1'b1;
               w_state_n = S_ROW_LO;
            end
            S_ROW_LO: begin
               w_row_ld    = 1'b1;
               w_push      = 1'b1;
               w_push_data = ANSWER_CODE;
               w_state_n   = S_PAYLOAD;
            end
            S_PAYLOAD: begin
               w_pay = 1'b1;
               if (w_cnt_inc == LB16) begin
                  w_state_n = CHECKSUM_EN ? S_CKSUM : S_ENDW;
               end else if (w_ack_hit) begin
                  w_push      = 1'b1;
                  w_push_data = ANSWER_CODE;
               end
            end
            S_CKSUM: begin
               w_ck_ld   = 1'b1;
               w_state_n = S_ENDW;
            end
            S_ENDW: begin
               w_push = 1'b1;
               if (rx_data == END_CODE && (!CHECKSUM_EN || r_ck_ok)) begin
                  w_push_data = SUCCESS_CODE;
                  w_done      = 1'b1;
               end else begin
                  w_push_data = NACK_CODE;
                  w_err       = 1'b1;
               end
               w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
         endcase
      end
   end

   // Frame datapath: row, byte count, checksum, ACK spacing, buffer write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_hi  <= '0;
         r_row     <= '0;
         r_count   <= '0;
         r_ack_cnt <= '0;
         r_cksum   <= '0;
         r_ck_ok   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= w_pay;
         r_done  <= w_done;
         r_err   <= w_err;
         if (w_start) begin
            r_count   <= '0;
            r_ack_cnt <= '0;
            r_cksum   <= '0;
            r_ck_ok   <= 1'b0;
         end
         if (w_hi_ld)  r_row_hi <= rx_data;
         if (w_row_ld) r_row    <= ROW_W'({r_row_hi, rx_data});
         if (w_pay) begin
            r_wr_addr <= ADDR_W'(r_count);
            r_wr_data <= rx_data;
            r_count   <= w_cnt_inc;
            r_cksum   <= r_cksum ^ rx_data;
            r_ack_cnt <= w_ack_hit ? 16'd0 : r_ack_cnt + 16'd1;
         end
         if (w_ck_ld) r_ck_ok <= (rx_data == r_cksum);
      end
   end

   // Inter-byte idle counter, held at zero while waiting for a frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            r_tmo_cnt <= '0;
      else if (r_state == S_IDLE || rx_valid) r_tmo_cnt <= '0;
      else                                r_tmo_cnt <= r_tmo_cnt + 32'd1;
   end

   // Response queue: when full, a push replaces the newest entry so the final
   // status byte always survives a stalled transmitter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q0       <= '0;
         r_q1       <= '0;
         r_qcnt     <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_start <= w_pop;
         if (w_pop) r_tx_data <= r_q0;
         case ({w_push, w_pop})
            2'b10: begin
               if (r_qcnt == 2'd0) begin
                  r_q0   <= w_push_data;
                  r_qcnt <= 2'd1;
               end else begin
                  r_q1   <= w_push_data;
                  r_qcnt <= 2'd2;
               end
            end
            2'b01: begin
               r_q0   <= r_q1;
               r_qcnt <= r_qcnt - 2'd1;
            end
            2'b11: begin
               if (r_qcnt == 2'd1) begin
                  r_q0 <= w_push_data;
               end else begin
                  r_q0 <= r_q1;
                  r_q1 <= w_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign tx_start  = r_tx_start;
   assign tx_data   = r_tx_data;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign row       = r_row;
   assign line_done = r_done;
   assign line_err  = r_err;
   assign active    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_line_loader.sv
// Testbench for uart_line_loader: one instance with short lines, checksum,
// ACK every 16 bytes and a 1000-cycle timeout; one instance with defaults.
module tb_uart_line_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- instance A ----------------
   logic       a_rx_valid, a_tx_busy;
   logic [7:0] a_rx_data;
   logic       a_tx_start, a_wr_en, a_done, a_err, a_active;
   logic [7:0] a_tx_data, a_wr_data;
   logic [5:0] a_wr_addr;
   logic [8:0] a_row;

   uart_line_loader #(
      .LINE_BYTES(64), .ROW_W(9), .ADDR_W(6), .ACK_EVERY(16),
      .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(1000)
   ) u_a (
      .clk(clk), .rst(rst), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
      .tx_busy(a_tx_busy), .tx_start(a_tx_start), .tx_data(a_tx_data),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .row(a_row), .line_done(a_done), .line_err(a_err), .active(a_active)
   );

   // ---------------- instance B (defaults) ----------------
   logic       b_rx_valid;
   logic [7:0] b_rx_data;
   logic       b_tx_start, b_wr_en, b_done, b_err, b_active;
   logic [7:0] b_tx_data, b_wr_data, b_wr_addr;
   logic [8:0] b_row;

   uart_line_loader u_b (
      .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
      .tx_busy(1'b0), .tx_start(b_tx_start), .tx_data(b_tx_data),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .row(b_row), .line_done(b_done), .line_err(b_err), .active(b_active)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitors (sample on falling edge) ----------------
   logic [7:0] a_log[$];
   int a_wr_cnt = 0, a_done_cnt = 0, a_err_cnt = 0, a_err_cyc = 0, last_a_rx = 0;

   always @(negedge clk) begin
      if (a_tx_start) a_log.push_back(a_tx_data);
      if (a_wr_en) begin
         a_wr_cnt++;
         check("a_wr_data", 32'(a_wr_data), 32'(a_wr_addr) + 32'd1);
      end
      if (a_done) a_done_cnt++;
      if (a_err) begin
         a_err_cnt++;
         a_err_cyc = cyc;
      end
   end

   int b_aa = 0, b_ff = 0, b_nack = 0, b_wr = 0, b_done_cnt = 0, b_err_cnt = 0;
   logic [7:0] b_last = 8'h00;

   always @(negedge clk) begin
      if (b_tx_start) begin
         if (b_tx_data == 8'hAA) b_aa++;
         else if (b_tx_data == 8'hFF) b_ff++;
         else if (b_tx_data == 8'h11) b_nack++;
         b_last = b_tx_data;
      end
      if (b_wr_en) begin
         b_wr++;
         check("b_wr_data", 32'(b_wr_data), 32'(b_wr_addr));
      end
      if (b_done) b_done_cnt++;
      if (b_err) b_err_cnt++;
   end

   function automatic logic [7:0] a_at(input int i);
      logic [7:0] none;
      none = 8'hxx;
      if (i < a_log.size()) return a_log[i];
      return none;
   endfunction

   // ---------------- drivers ----------------
   task automatic send_a(input logic [7:0] b);
      @(negedge clk);
      a_rx_valid = 1'b1;
      a_rx_data  = b;
      @(negedge clk);
      a_rx_valid = 1'b0;
      last_a_rx  = cyc;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk);
      b_rx_valid = 1'b1;
      b_rx_data  = b;
      @(negedge clk);
      b_rx_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic frame_a(input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] ck, input logic [7:0] endb);
      send_a(8'hA5);
      send_a(hi);
      send_a(lo);
      for (int i = 0; i < 64; i++) send_a(8'(i + 1));
      send_a(ck);
      send_a(endb);
   endtask

   task automatic frame_b(input logic [7:0] endb);
      send_b(8'hA5);
      send_b(8'h00);
      send_b(8'h07);
      for (int i = 0; i < 240; i++) send_b(8'(i));
      send_b(endb);
   endtask

   typedef struct {
      string      name;
      logic [7:0] hi, lo, ck, endb;
      logic [8:0] row;
      logic [7:0] status;
      int         done, err;
   } vec_t;

   vec_t vt[5];
   int   bl, bw, bd, be;
   int   baa, bff, bnk, bbw, bbd, bbe;

   initial begin
      // XOR of 0x01..0x40 is 0x40
      vt[0] = '{"good_r7",    8'h00, 8'h07, 8'h40, 8'hDD, 9'h007, 8'hFF, 1, 0};
      vt[1] = '{"bad_cksum",  8'h00, 8'h07, 8'h00, 8'hDD, 9'h007, 8'h11, 0, 1};
      vt[2] = '{"good_r123",  8'h01, 8'h23, 8'h40, 8'hDD, 9'h123, 8'hFF, 1, 0};
      vt[3] = '{"bad_end",    8'h12, 8'h34, 8'h40, 8'h3C, 9'h034, 8'h11, 0, 1};
      vt[4] = '{"good_rmax",  8'hFF, 8'hFF, 8'h40, 8'hDD, 9'h1FF, 8'hFF, 1, 0};

      rst = 1'b1;
      a_rx_valid = 1'b0; a_rx_data = 8'h00; a_tx_busy = 1'b0;
      b_rx_valid = 1'b0; b_rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx_start", 32'(a_tx_start), 0);
      check("rst_wr_en",    32'(a_wr_en), 0);
      check("rst_row",      32'(a_row), 0);
      check("rst_active",   32'(a_active), 0);
      check("rst_done_err", 32'({a_done, a_err}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // garbage in IDLE
      bl = a_log.size(); bw = a_wr_cnt;
      send_a(8'h00); send_a(8'hDD); send_a(8'h55);
      repeat (5) @(negedge clk);
      check("garbage_tx",     32'(a_log.size() - bl), 0);
      check("garbage_wr",     32'(a_wr_cnt - bw), 0);
      check("garbage_active", 32'(a_active), 0);

      // timeout after 10 payload bytes, first byte checks write latency
      bl = a_log.size(); bw = a_wr_cnt; bd = a_done_cnt; be = a_err_cnt;
      send_a(8'hA5); send_a(8'h00); send_a(8'h05);
      @(negedge clk);
      a_rx_valid = 1'b1; a_rx_data = 8'h01;
      @(negedge clk);
      a_rx_valid = 1'b0;
      check("lat_wr_en",   32'(a_wr_en), 1);
      check("lat_wr_addr", 32'(a_wr_addr), 0);
      check("lat_wr_data", 32'(a_wr_data), 32'h01);
      @(negedge clk);
      check("lat_wr_pulse", 32'(a_wr_en), 0);
      @(negedge clk);
      for (int i = 1; i < 10; i++) send_a(8'(i + 1));
      check("tmo_active_before", 32'(a_active), 1);
      repeat (1010) @(negedge clk);
      check("tmo_err_cnt",  32'(a_err_cnt - be), 1);
      check("tmo_latency",  32'(a_err_cyc - last_a_rx), 1000);
      check("tmo_ntx",      32'(a_log.size() - bl), 2);
      check("tmo_ack",      32'(a_at(bl)), 32'hAA);
      check("tmo_code",     32'(a_at(bl + 1)), 32'h22);
      check("tmo_active",   32'(a_active), 0);
      check("tmo_done",     32'(a_done_cnt - bd), 0);
      check("tmo_wr",       32'(a_wr_cnt - bw), 10);

      // table-driven frames
      for (int k = 0; k < 5; k++) begin
         bl = a_log.size(); bw = a_wr_cnt; bd = a_done_cnt; be = a_err_cnt;
         frame_a(vt[k].hi, vt[k].lo, vt[k].ck, vt[k].endb);
         repeat (8) @(negedge clk);
         check($sformatf("%s_row", vt[k].name), 32'(a_row), 32'(vt[k].row));
         check($sformatf("%s_ntx", vt[k].name), 32'(a_log.size() - bl), 5);
         for (int j = 0; j < 4; j++)
            check($sformatf("%s_ack%0d", vt[k].name, j), 32'(a_at(bl + j)), 32'hAA);
         check($sformatf("%s_status", vt[k].name), 32'(a_at(bl + 4)), 32'(vt[k].status));
         check($sformatf("%s_nwr", vt[k].name), 32'(a_wr_cnt - bw), 64);
         check($sformatf("%s_done", vt[k].name), 32'(a_done_cnt - bd), 32'(vt[k].done));
         check($sformatf("%s_err", vt[k].name), 32'(a_err_cnt - be), 32'(vt[k].err));
         check($sformatf("%s_active", vt[k].name), 32'(a_active), 0);
      end

      // transmitter stalled through the whole frame
      a_tx_busy = 1'b1;
      bl = a_log.size(); bd = a_done_cnt;
      frame_a(8'h00, 8'h09, 8'h40, 8'hDD);
      repeat (8) @(negedge clk);
      check("busy_held_tx", 32'(a_log.size() - bl), 0);
      check("busy_done",    32'(a_done_cnt - bd), 1);
      a_tx_busy = 1'b0;
      repeat (10) @(negedge clk);
      check("busy_ntx",   32'(a_log.size() - bl), 2);
      check("busy_first", 32'(a_at(bl)), 32'hAA);
      check("busy_last",  32'(a_at(bl + 1)), 32'hFF);

      // asynchronous reset in the middle of the payload
      bd = a_done_cnt; be = a_err_cnt;
      send_a(8'hA5); send_a(8'h00); send_a(8'h07);
      for (int i = 0; i < 5; i++) send_a(8'(i + 1));
      repeat (4) @(negedge clk);
      bl = a_log.size();
      @(negedge clk);
      a_rx_valid = 1'b1; a_rx_data = 8'h06;
      @(posedge clk);
      #1;
      check("mid_wr_en_pre", 32'(a_wr_en), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en",  32'(a_wr_en), 0);
      check("mid_rst_active", 32'(a_active), 0);
      check("mid_rst_row",    32'(a_row), 0);
      check("mid_rst_txdata", 32'(a_tx_data), 0);
      check("mid_rst_addr",   32'({a_wr_addr, a_wr_data}), 0);
      @(negedge clk);
      a_rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("mid_rst_ntx",  32'(a_log.size() - bl), 0);
      check("mid_rst_err",  32'(a_err_cnt - be), 0);
      check("mid_rst_done", 32'(a_done_cnt - bd), 0);

      // default-parameter instance: good then bad end code
      baa = b_aa; bff = b_ff; bnk = b_nack; bbw = b_wr; bbd = b_done_cnt; bbe = b_err_cnt;
      frame_b(8'hDD);
      repeat (8) @(negedge clk);
      check("def_row",  32'(b_row), 7);
      check("def_aa",   32'(b_aa - baa), 240);
      check("def_ff",   32'(b_ff - bff), 1);
      check("def_nack", 32'(b_nack - bnk), 0);
      check("def_last", 32'(b_last), 32'hFF);
      check("def_nwr",  32'(b_wr - bbw), 240);
      check("def_done", 32'(b_done_cnt - bbd), 1);
      check("def_err",  32'(b_err_cnt - bbe), 0);

      baa = b_aa; bff = b_ff; bnk = b_nack; bbd = b_done_cnt; bbe = b_err_cnt;
      frame_b(8'h3C);
      repeat (8) @(negedge clk);
      check("defbad_aa",     32'(b_aa - baa), 240);
      check("defbad_nack",   32'(b_nack - bnk), 1);
      check("defbad_ff",     32'(b_ff - bff), 0);
      check("defbad_last",   32'(b_last), 32'h11);
      check("defbad_done",   32'(b_done_cnt - bbd), 0);
      check("defbad_err",    32'(b_err_cnt - bbe), 1);
      check("defbad_active", 32'(b_active), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
